mem_port_arbiter: RTL

//  Shares one single-ported unified memory between IF-stage instruction fetch and MEM-stage load/store.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle linking the fetch and data requesters, the memory-port arbiter
// and the single-ported memory array.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        stall;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    // Pipeline / memory side
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store, with
// programmable wait states and IF starvation relief. Define MEM_ARB_STATS_EN for grant/stall counters.
module mem_port_arbiter #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned STARVE_MAX  = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  if_grants,
    output logic [CNT_W-1:0]  dm_grants,
    output logic [CNT_W-1:0]  stall_cycles
`endif
);

    localparam int unsigned WCNT_W   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    if (CNT_W == 0) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         dm_rdata_q, dm_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic                dm_ready_q, dm_ready_d;

    logic if_elig, dm_elig, if_favoured, if_grant, dm_grant;

    // A requester whose completion pulse is showing is not competing this cycle.
    assign if_elig     = bus.if_req & ~if_ready_q;
    assign dm_elig     = bus.dm_req & ~dm_ready_q;
    assign if_favoured = (STARVE_MAX != 0) && (starve_cnt_q == STARVE_W'(STARVE_MAX)) && if_elig;
    assign dm_grant    = (state_q == IDLE) && dm_elig && !if_favoured;
    assign if_grant    = (state_q == IDLE) && if_elig && !dm_grant;

    assign bus.stall     = if_elig | dm_elig;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.dm_ready  = dm_ready_q;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_ready_d   = 1'b0;
        dm_ready_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (dm_grant) begin
                    state_d     = BUSY_DM;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    if ((STARVE_MAX != 0) && if_elig && (starve_cnt_q != STARVE_W'(STARVE_MAX))) begin
                        starve_cnt_d = starve_cnt_q + STARVE_W'(1);
                    end
                end else if (if_grant) begin
                    state_d      = BUSY_IF;
                    mem_en_d     = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = bus.if_addr;
                    starve_cnt_d = '0;
                end else if (!bus.if_req) begin
                    starve_cnt_d = '0;
                end
            end
            BUSY_IF, BUSY_DM: begin
                wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                // Last wait state: memory data is valid now, release the port.
                if (wait_cnt_q == WCNT_W'(WAIT_STATES)) begin
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == BUSY_DM) begin
                        dm_rdata_d = bus.mem_rdata;
                        dm_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                        if_ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_ready_q   <= 1'b0;
            dm_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ready_q   <= if_ready_d;
            dm_ready_q   <= dm_ready_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [CNT_W-1:0] if_grants_q, if_grants_d;
    logic [CNT_W-1:0] dm_grants_q, dm_grants_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    // Saturating event counters.
    always_comb begin
        if_grants_d    = if_grants_q;
        dm_grants_d    = dm_grants_q;
        stall_cycles_d = stall_cycles_q;
        if (if_grant && !(&if_grants_q))       if_grants_d    = if_grants_q + CNT_W'(1);
        if (dm_grant && !(&dm_grants_q))       dm_grants_d    = dm_grants_q + CNT_W'(1);
        if (bus.stall && !(&stall_cycles_q))   stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            if_grants_q    <= '0;
            dm_grants_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            if_grants_q    <= if_grants_d;
            dm_grants_q    <= dm_grants_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign if_grants    = if_grants_q;
    assign dm_grants    = dm_grants_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule
